alu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the 8-bit, 4-op ALU datapath of the simple ISA CPU.
- Fetches 16-bit instructions over a request/valid instruction-memory port.
- Decodes each instruction, reads operands from a 4x8 register file, drives the existing alu, writes results back and updates the PC.
- Sits between instruction memory and the alu. Serves as the RTL CPU core compared against the ISA golden model.

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu.sv | 25 ++
 rtl/alu_seq_ctrl_regfile_4x8.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl sequencer: FSM states,
// opcodes, ALU operation codes and instruction field positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_BEQZ = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int ALUOP_MSB = 11;
  localparam int ALUOP_LSB = 10;
  localparam int RD_MSB    = 9;
  localparam int RD_LSB    = 8;
  localparam int RS_MSB    = 7;
  localparam int RS_LSB    = 6;
  localparam int RT_MSB    = 5;
  localparam int RT_LSB    = 4;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/alu.sv
// 8-bit, 4-operation combinational ALU with zero flag; arithmetic wraps.
module alu
  import alu_seq_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] result,
  output logic       zero_flag
);

  always_comb begin
    result = 8'h00;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = 8'h00;
    endcase
  end

  assign zero_flag = (result == 8'h00);

endmodule

// File: rtl/alu_seq_ctrl_regfile_4x8.sv
// 4x8 register file: one synchronous write port, two combinational operand
// reads and a combinational debug read. Cleared by synchronous reset.
module regfile_4x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  input  logic [1:0] dbg_sel,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [7:0] dbg_data
);

  logic [7:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the 8-bit ALU and a
// 4x8 register file from a 16-bit request/valid instruction memory.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | imem_req held at pc until imem_valid or fetch timeout
// DECODE  | latch operands reg[rs], reg[rt]
// EXECUTE | writeback, zflag and pc update, retire pulse
// HALT    | terminal until reset (HALT opcode, illegal opcode, timeout)
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter int         FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        fetch_err,
  output logic        retire,
  output logic [7:0]  pc_out,
  output logic        zflag,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  pc, pc_nxt;
  logic [15:0] ir, ir_nxt;
  logic [7:0]  opnd_a, opnd_a_nxt;
  logic [7:0]  opnd_b, opnd_b_nxt;
  logic        zflag_q, zflag_nxt;
  logic        illegal_q, illegal_nxt;
  logic        fetch_err_q, fetch_err_nxt;
  logic [7:0]  tmo_cnt, tmo_cnt_nxt;
  logic        retire_c;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata_a, rf_rdata_b;
  logic [7:0]  alu_result;
  logic        alu_zero;

  logic [3:0]  opcode;
  logic [1:0]  fld_aluop, fld_rd, fld_rs, fld_rt;
  logic [7:0]  fld_imm;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign fld_aluop = ir[ALUOP_MSB:ALUOP_LSB];
  assign fld_rd    = ir[RD_MSB:RD_LSB];
  assign fld_rs    = ir[RS_MSB:RS_LSB];
  assign fld_rt    = ir[RT_MSB:RT_LSB];
  assign fld_imm   = ir[IMM_MSB:IMM_LSB];

  regfile_4x8 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (fld_rd),
    .wdata    (rf_wdata),
    .raddr_a  (fld_rs),
    .raddr_b  (fld_rt),
    .dbg_sel  (dbg_sel),
    .rdata_a  (rf_rdata_a),
    .rdata_b  (rf_rdata_b),
    .dbg_data (dbg_data)
  );

  alu u_alu (
    .a         (opnd_a),
    .b         (opnd_b),
    .op        (fld_aluop),
    .result    (alu_result),
    .zero_flag (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= 16'h0000;
      opnd_a      <= 8'h00;
      opnd_b      <= 8'h00;
      zflag_q     <= 1'b0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
      tmo_cnt     <= 8'h00;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ir          <= ir_nxt;
      opnd_a      <= opnd_a_nxt;
      opnd_b      <= opnd_b_nxt;
      zflag_q     <= zflag_nxt;
      illegal_q   <= illegal_nxt;
      fetch_err_q <= fetch_err_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    opnd_a_nxt    = opnd_a;
    opnd_b_nxt    = opnd_b;
    zflag_nxt     = zflag_q;
    illegal_nxt   = illegal_q;
    fetch_err_nxt = fetch_err_q;
    tmo_cnt_nxt   = tmo_cnt;
    retire_c      = 1'b0;
    rf_we         = 1'b0;
    rf_wdata      = fld_imm;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_valid) begin
          ir_nxt      = imem_data;
          tmo_cnt_nxt = 8'h00;
          state_nxt   = DECODE;
        end else if (tmo_cnt == TMO_LAST) begin
          fetch_err_nxt = 1'b1;
          tmo_cnt_nxt   = 8'h00;
          state_nxt     = HALT;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      DECODE: begin
        opnd_a_nxt = rf_rdata_a;
        opnd_b_nxt = rf_rdata_b;
        state_nxt  = EXECUTE;
      end
      EXECUTE: begin
        state_nxt = FETCH;
        retire_c  = 1'b1;
        pc_nxt    = pc + 8'd1;
        case (opcode)
          OP_NOP: ;
          OP_ALU: begin
            rf_we     = 1'b1;
            rf_wdata  = alu_result;
            zflag_nxt = alu_zero;
          end
          OP_LDI:  rf_we = 1'b1;
          OP_BEQZ: if (zflag_q) pc_nxt = fld_imm;
          OP_JMP:  pc_nxt = fld_imm;
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = HALT;
          end
          default: begin
            // undefined opcode: nothing architectural changes except the flag
            pc_nxt      = pc;
            retire_c    = 1'b0;
            illegal_nxt = 1'b1;
            state_nxt   = HALT;
          end
        endcase
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign busy      = (state == FETCH) || (state == DECODE) || (state == EXECUTE);
  assign halted    = (state == HALT);
  assign illegal   = illegal_q;
  assign fetch_err = fetch_err_q;
  assign retire    = retire_c;
  assign pc_out    = pc;
  assign zflag     = zflag_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed programs push expected fetches
// and retires; a monitor pops and compares as the DUT presents them.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        busy, halted, illegal, fetch_err, retire, zflag;
  logic [7:0]  pc_out;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .busy(busy), .halted(halted), .illegal(illegal), .fetch_err(fetch_err),
    .retire(retire), .pc_out(pc_out), .zflag(zflag),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    int         len;
  } fetch_t;

  logic [15:0] mem [256];
  fetch_t      fetch_q [$];
  logic [7:0]  retire_q [$];
  int          checks = 0;
  int          failures = 0;
  int          retire_cnt = 0;
  int          last_abort_run = 0;
  int          resp_delay = 0;
  bit          no_resp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] i_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'h2, 2'b00, rd, imm};
  endfunction
  function automatic logic [15:0] i_alu(input logic [1:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt);
    return {4'h1, op, rd, rs, rt, 4'h0};
  endfunction
  function automatic logic [15:0] i_beqz(input logic [7:0] t);
    return {4'h3, 4'h0, t};
  endfunction
  function automatic logic [15:0] i_jmp(input logic [7:0] t);
    return {4'h4, 4'h0, t};
  endfunction

  // instruction memory responder: valid after resp_delay wait cycles
  int wcnt = 0;
  always @(negedge clk) begin
    if (imem_req && !no_resp) begin
      if (wcnt == resp_delay) begin
        imem_valid = 1'b1;
        imem_data  = mem[imem_addr];
        wcnt       = 0;
      end else begin
        imem_valid = 1'b0;
        wcnt++;
      end
    end else begin
      imem_valid = 1'b0;
      wcnt       = 0;
    end
  end

  // monitor: fetch handshakes and retire pulses against the expected queues
  int         run = 0;
  logic [7:0] run_addr = 8'h00;
  always @(negedge clk) begin
    #1;
    if (imem_req) begin
      if (run == 0) run_addr = imem_addr;
      else if (imem_addr !== run_addr) chk("fetch_addr_stable", imem_addr, run_addr);
      run++;
      if (imem_valid) begin
        if (fetch_q.size() == 0) chk("fetch_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
        else begin
          fetch_t f;
          f = fetch_q.pop_front();
          chk("fetch_addr", imem_addr, f.addr);
          chk("fetch_len", run, f.len);
        end
        run = 0;
      end
    end else begin
      if (run != 0) last_abort_run = run;
      run = 0;
    end
    if (retire) begin
      retire_cnt++;
      if (retire_q.size() == 0) chk("retire_unexpected", 32'(pc_out), 32'hFFFF_FFFF);
      else chk("retire_pc", pc_out, retire_q.pop_front());
    end
  end

  task automatic exp_seq(input logic [7:0] pcs [$], input int len);
    foreach (pcs[i]) begin
      fetch_t f;
      f.addr = pcs[i];
      f.len  = len;
      fetch_q.push_back(f);
      retire_q.push_back(pcs[i]);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk({nm, "_halt_timeout"}, 0, 1);
    #2;
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] r, input logic [7:0] v);
    dbg_sel = r;
    #1;
    chk(nm, dbg_data, v);
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_fetch_q_empty"}, fetch_q.size(), 0);
    chk({nm, "_retire_q_empty"}, retire_q.size(), 0);
    fetch_q.delete();
    retire_q.delete();
  endtask

  initial begin
    int base;
    int n;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    do_reset();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_retire", retire, 0);
    chk("rst_flags", {zflag, illegal, fetch_err}, 0);
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", 2'(r), 8'h00);

    // 1: LDI/LDI/ADD/HALT
    clear_mem();
    mem[0] = i_ldi(0, 8'd5); mem[1] = i_ldi(1, 8'd3);
    mem[2] = i_alu(2'b00, 2, 0, 1); mem[3] = 16'hF000;
    exp_seq('{8'h00, 8'h01, 8'h02, 8'h03}, 1);
    do_reset(); base = retire_cnt; do_start(); wait_halt("t1");
    chk_reg("t1_r2", 2, 8'd8);
    chk_reg("t1_r0", 0, 8'd5);
    chk("t1_zflag", zflag, 0);
    chk("t1_retires", retire_cnt - base, 4);
    chk("t1_halted", halted, 1);
    chk("t1_pc", pc_out, 8'h03);
    chk("t1_busy", busy, 0);
    chk("t1_err", {illegal, fetch_err}, 0);
    chk_drained("t1");

    // 2a: SUB to zero, BEQZ taken
    clear_mem();
    mem[0] = i_ldi(0, 8'd7); mem[1] = i_alu(2'b01, 3, 0, 0);
    mem[2] = i_beqz(8'h10); mem[8'h10] = 16'hF000;
    exp_seq('{8'h00, 8'h01, 8'h02, 8'h10}, 1);
    do_reset(); do_start(); wait_halt("t2a");
    chk("t2a_zflag", zflag, 1);
    chk_reg("t2a_r3", 3, 8'h00);
    chk("t2a_pc", pc_out, 8'h10);
    chk_drained("t2a");

    // 2b: AND -> 0x04, BEQZ falls through, OR -> 0x0E
    clear_mem();
    mem[0] = i_ldi(0, 8'h0C); mem[1] = i_ldi(1, 8'h06);
    mem[2] = i_alu(2'b10, 2, 0, 1); mem[3] = i_beqz(8'h20);
    mem[4] = i_alu(2'b11, 3, 0, 1); mem[5] = 16'hF000;
    exp_seq('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1);
    do_reset(); do_start(); wait_halt("t2b");
    chk_reg("t2b_r2_and", 2, 8'h04);
    chk_reg("t2b_r3_or", 3, 8'h0E);
    chk("t2b_zflag", zflag, 0);
    chk("t2b_pc", pc_out, 8'h05);
    chk_drained("t2b");

    // 3a: imem_valid delayed 5 cycles on every fetch
    clear_mem();
    mem[0] = i_ldi(1, 8'h5A); mem[1] = 16'hF000;
    exp_seq('{8'h00, 8'h01}, 6);
    resp_delay = 5;
    do_reset(); do_start(); wait_halt("t3a");
    chk_reg("t3a_r1", 1, 8'h5A);
    chk("t3a_pc", pc_out, 8'h01);
    chk_drained("t3a");

    // 3b: imem_valid never arrives
    no_resp = 1'b1;
    do_reset(); base = retire_cnt; last_abort_run = 0;
    do_start(); wait_halt("t3b");
    chk("t3b_fetch_err", fetch_err, 1);
    chk("t3b_illegal", illegal, 0);
    chk("t3b_timeout_len", last_abort_run, 16);
    chk("t3b_retires", retire_cnt - base, 0);
    chk("t3b_busy", busy, 0);
    no_resp = 1'b0;
    resp_delay = 0;
    chk_drained("t3b");

    // 4: illegal opcode at pc 0x02
    clear_mem();
    mem[0] = i_ldi(0, 8'h11); mem[1] = i_ldi(1, 8'h22);
    mem[2] = 16'h7123; mem[3] = i_ldi(0, 8'h99);
    fetch_q.push_back('{8'h02, 1});
    exp_seq('{8'h00, 8'h01}, 1);
    fetch_q.push_back(fetch_q.pop_front());
    do_reset(); base = retire_cnt; do_start(); wait_halt("t4");
    chk("t4_illegal", illegal, 1);
    chk("t4_fetch_err", fetch_err, 0);
    chk("t4_pc", pc_out, 8'h02);
    chk("t4_retires", retire_cnt - base, 2);
    chk_reg("t4_r0", 0, 8'h11);
    chk_reg("t4_r1", 1, 8'h22);
    chk_reg("t4_r2", 2, 8'h00);
    chk_reg("t4_r3", 3, 8'h00);
    chk_drained("t4");

    // 5a: reset while a fetch is outstanding
    clear_mem();
    mem[0] = i_ldi(0, 8'h33); mem[1] = i_ldi(1, 8'h44);
    resp_delay = 8;
    exp_seq('{8'h00}, 9);
    do_reset(); do_start();
    n = 0;
    while (!(imem_req && pc_out == 8'h01) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5a_in_fetch", {imem_req, pc_out}, {1'b1, 8'h01});
    chk_reg("t5a_r0_before", 0, 8'h33);
    rst = 1'b1;
    @(negedge clk);
    chk("t5a_imem_req", imem_req, 0);
    chk("t5a_pc", pc_out, 8'h00);
    chk("t5a_busy_halted", {busy, halted}, 0);
    rst = 1'b0;
    chk_reg("t5a_r0", 0, 8'h00);
    resp_delay = 0;
    #2;
    chk_drained("t5a");

    // 5b: reset during EXECUTE of an ADD
    clear_mem();
    mem[0] = i_ldi(0, 8'h01); mem[1] = i_ldi(1, 8'h02);
    mem[2] = i_alu(2'b00, 2, 0, 1);
    exp_seq('{8'h00, 8'h01, 8'h02}, 1);
    do_reset(); do_start();
    n = 0;
    while (!(retire && pc_out == 8'h02) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5b_in_exec", {retire, pc_out}, {1'b1, 8'h02});
    rst = 1'b1;
    @(negedge clk);
    chk("t5b_imem_req", imem_req, 0);
    chk("t5b_pc", pc_out, 8'h00);
    chk("t5b_zflag", zflag, 0);
    rst = 1'b0;
    chk_reg("t5b_r2", 2, 8'h00);
    chk_reg("t5b_r0", 0, 8'h00);
    #2;
    chk_drained("t5b");

    // 6a: pc wraps 0xFF -> 0x00
    clear_mem();
    mem[0] = i_beqz(8'h05); mem[1] = i_alu(2'b01, 3, 3, 3);
    mem[2] = i_jmp(8'hFF); mem[8'hFF] = 16'h0000; mem[5] = 16'hF000;
    exp_seq('{8'h00, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h05}, 1);
    do_reset(); do_start(); wait_halt("t6a");
    chk("t6a_pc", pc_out, 8'h05);
    chk_drained("t6a");

    // 6b: 8-bit wrap in ADD, rd == rs/rt uses old operands
    clear_mem();
    mem[0] = i_ldi(0, 8'hC8); mem[1] = i_ldi(1, 8'h64);
    mem[2] = i_alu(2'b00, 2, 0, 1); mem[3] = i_beqz(8'h40);
    mem[4] = i_ldi(3, 8'h80); mem[5] = i_alu(2'b00, 3, 3, 3);
    mem[6] = i_beqz(8'h50); mem[8'h50] = 16'hF000;
    exp_seq('{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h50}, 1);
    do_reset(); do_start(); wait_halt("t6b");
    chk_reg("t6b_r2", 2, 8'h2C);
    chk_reg("t6b_r3", 3, 8'h00);
    chk("t6b_zflag", zflag, 1);
    chk("t6b_pc", pc_out, 8'h50);
    chk_drained("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1, "global timeout");
  end

endmodule
